ascon_inv_permutation_iter: RTL and testbench

//  Iterative inverse Ascon permutation: given state y and round count R (6/8/12), returns x with p_R(x)=y.

---
 rtl/ascon_pkg.sv | 66 ++++++
 rtl/ascon_inv_round.sv | 32 +++
 rtl/ascon_inv_permutation_iter.sv | 113 +++++++++++
 tb/tb_ascon_inv_permutation_iter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types, tables and helpers for the iterative inverse Ascon permutation.
// Feature macro ASCON_INV_ABORT_EN is consumed by the top level only.
package ascon_pkg;

  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } inv_st_t;

  localparam logic [1:0] RND_6  = 2'b00;
  localparam logic [1:0] RND_8  = 2'b01;
  localparam logic [1:0] RND_12 = 2'b10;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [4:0] inv_sbox(input logic [4:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (SBOX[i] == v) r = 5'(i);
    return r;
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] w,
                                        input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // (1+x^a+x^b)^-1 == (1+x^a+x^b)^63 in GF(2)[x]/(x^64+1)
  function automatic logic [63:0] inv_sigma(input logic [63:0] w,
                                            input int a,
                                            input int b);
    logic [63:0] t;
    t = w;
    for (int k = 0; k < 6; k++)
      t = t ^ ror64(t, (a << k) % 64) ^ ror64(t, (b << k) % 64);
    return t;
  endfunction

  function automatic logic [63:0] rc(input logic [3:0] r);
    return {56'h0, ~r, r};
  endfunction

  function automatic logic [3:0] last_round(input logic [1:0] sel);
    logic [3:0] l;
    case (sel)
      RND_6:   l = 4'd6;
      RND_8:   l = 4'd4;
      RND_12:  l = 4'd0;
      default: l = 4'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ascon_inv_round.sv
// Combinational single inverse Ascon round:
// inverse linear layer, inverse S-box, then round constant removal.
module ascon_inv_round
  import ascon_pkg::*;
(
  input  ascon_state_t i_s,
  input  logic [3:0]   i_r,
  output ascon_state_t o_s
);

  ascon_state_t w_lin;
  ascon_state_t w_sb;

  for (genvar i = 0; i < 5; i++) begin : g_lin
    assign w_lin[i] = inv_sigma(i_s[i], ROT_A[i], ROT_B[i]);
  end

  // x0 is the MSB of each column index
  for (genvar j = 0; j < 64; j++) begin : g_col
    assign {w_sb[0][j], w_sb[1][j], w_sb[2][j],
            w_sb[3][j], w_sb[4][j]} =
      inv_sbox({w_lin[0][j], w_lin[1][j], w_lin[2][j],
                w_lin[3][j], w_lin[4][j]});
  end

  assign o_s[0] = w_sb[0];
  assign o_s[1] = w_sb[1];
  assign o_s[2] = w_sb[2] ^ rc(i_r);
  assign o_s[3] = w_sb[3];
  assign o_s[4] = w_sb[4];

endmodule

// File: rtl/ascon_inv_permutation_iter.sv
// Iterative inverse Ascon permutation, UNROLL rounds per clock.
// Optional abort_i port when ASCON_INV_ABORT_EN is defined.
module ascon_inv_permutation_iter
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
`ifdef ASCON_INV_ABORT_EN
  input  logic        abort_i,
`endif
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("UNROLL must be 1 or 2");
  end

  inv_st_t      r_st;
  inv_st_t      w_nxt;
  ascon_state_t r_x;
  logic [3:0]   r_cnt;
  logic [3:0]   r_last;
  logic         w_fin;
  logic         w_abort;
  ascon_state_t w_st [UNROLL+1];

`ifdef ASCON_INV_ABORT_EN
  assign w_abort = abort_i && (r_st != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_st[0] = r_x;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    ascon_inv_round u_rnd (
      .i_s (w_st[g]),
      .i_r (r_cnt - 4'(g)),
      .o_s (w_st[g+1])
    );
  end

  // last pass of a job covers rounds r_cnt .. r_last
  assign w_fin = (r_cnt == r_last + 4'(UNROLL - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_st <= ST_IDLE;
    else       r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      ST_IDLE: if (in_valid_i)  w_nxt = ST_RUN;
      ST_RUN:  if (w_fin)       w_nxt = ST_DONE;
      ST_DONE: if (out_ready_i) w_nxt = ST_IDLE;
      default:                  w_nxt = ST_IDLE;
    endcase
    if (w_abort) w_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x    <= '0;
      r_cnt  <= 4'd11;
      r_last <= 4'd0;
    end else if (w_abort) begin
      r_x    <= '0;
      r_cnt  <= 4'd11;
    end else begin
      unique case (r_st)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_x    <= {x4_i, x3_i, x2_i, x1_i, x0_i};
            r_cnt  <= 4'd11;
            r_last <= last_round(rounds_i);
          end
        end
        ST_RUN: begin
          r_x <= w_st[UNROLL];
          if (!w_fin) r_cnt <= r_cnt - 4'(UNROLL);
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (r_st == ST_IDLE);
  assign out_valid_o = (r_st == ST_DONE);

  assign x0_o = out_valid_o ? r_x[0] : 64'h0;
  assign x1_o = out_valid_o ? r_x[1] : 64'h0;
  assign x2_o = out_valid_o ? r_x[2] : 64'h0;
  assign x3_o = out_valid_o ? r_x[3] : 64'h0;
  assign x4_o = out_valid_o ? r_x[4] : 64'h0;

endmodule

// File: tb/tb_ascon_inv_permutation_iter.sv
// Self-checking bench: forward Ascon model drives round-trip checks
// of the inverse permutation (latency, hold, reset, abort).
module tb_ascon_inv_permutation_iter;

  typedef logic [4:0][63:0] st5_t;

  localparam int UNR = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  rounds = 2'b10;
  logic [63:0] xi [5];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] xo [5];
`ifdef ASCON_INV_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ascon_inv_permutation_iter #(.UNROLL(UNR)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .rounds_i    (rounds),
    .x0_i        (xi[0]),
    .x1_i        (xi[1]),
    .x2_i        (xi[2]),
    .x3_i        (xi[3]),
    .x4_i        (xi[4]),
`ifdef ASCON_INV_ABORT_EN
    .abort_i     (abort),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .x0_o        (xo[0]),
    .x1_o        (xo[1]),
    .x2_o        (xo[2]),
    .x3_o        (xo[3]),
    .x4_o        (xo[4])
  );

  always #5 clk = ~clk;

  localparam logic [4:0] SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // forward p_R: rounds 12-R .. 11 of constant, S-box, linear layer
  function automatic st5_t perm(input st5_t s, input int r_n);
    st5_t t;
    logic [4:0] v;
    for (int i = 12 - r_n; i < 12; i++) begin
      s[2] = s[2] ^ 64'(((15 - i) << 4) | i);
      for (int j = 0; j < 64; j++) begin
        v = SB[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
        t[0][j] = v[4]; t[1][j] = v[3]; t[2][j] = v[2];
        t[3][j] = v[1]; t[4][j] = v[0];
      end
      for (int w = 0; w < 5; w++)
        s[w] = t[w] ^ ror(t[w], RA[w]) ^ ror(t[w], RB[w]);
    end
    return s;
  endfunction

  function automatic int nrounds(input logic [1:0] sel);
    return (sel == 2'b00) ? 6 : (sel == 2'b01) ? 8 : 12;
  endfunction

  function automatic st5_t rnd_state();
    st5_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input st5_t obs,
                           input st5_t exp);
    for (int w = 0; w < 5; w++)
      chk($sformatf("%s.x%0d", tag, w), obs[w], exp[w]);
  endtask

  function automatic st5_t outs();
    st5_t s;
    for (int w = 0; w < 5; w++) s[w] = xo[w];
    return s;
  endfunction

  task automatic drive(input st5_t y, input logic [1:0] sel);
    for (int w = 0; w < 5; w++) xi[w] = y[w];
    rounds   = sel;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rounds   = 2'($urandom);
    for (int w = 0; w < 5; w++) xi[w] = {$urandom, $urandom};
  endtask

  // accept y, wait for result, optionally stall / poke in DONE
  task automatic run_job(input string tag, input st5_t y,
                         input logic [1:0] sel, input int hold,
                         input bit poke, output st5_t res);
    int n;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    drive(y, sel);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n + 1), 64'(nrounds(sel) / UNR + 1));
    res = outs();
    for (int h = 0; h < hold; h++) begin
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      chk_state({tag, ".hold"}, outs(), res);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    if (poke) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (poke) begin
      chk({tag, ".poke_idle"}, 64'(in_ready), 64'd1);
      chk({tag, ".poke_nov"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    st5_t x, y, res, res2;
    logic [1:0] sel;
    bit seen;

    for (int w = 0; w < 5; w++) xi[w] = '0;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk_state("rst.out", outs(), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_job("zero", '0, 2'b10, 0, 0, res);
    chk_state("zero.fwd", perm(res, 12), '0);

    for (int i = 0; i < 50; i++) begin
      for (int k = 0; k < 3; k++) begin
        sel = 2'(k);
        x = rnd_state();
        y = perm(x, nrounds(sel));
        run_job($sformatf("rnd%0d_r%0d", i, nrounds(sel)),
                y, sel, 0, 0, res);
        chk_state($sformatf("rnd%0d_r%0d", i, nrounds(sel)), res, x);
      end
    end

    x = rnd_state();
    run_job("stall", perm(x, 8), 2'b01, 5, 1, res);
    chk_state("stall", res, x);

    x = rnd_state();
    y = perm(x, 12);
    run_job("r10", y, 2'b10, 0, 0, res);
    run_job("r11", y, 2'b11, 0, 0, res2);
    chk_state("r11_vs_r10", res2, res);
    chk_state("r11", res2, x);

    x = rnd_state();
    drive(perm(x, 12), 2'b10);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'd0);
    chk("mrst.in_ready", 64'(in_ready), 64'd1);
    chk_state("mrst.out", outs(), '0);
    @(posedge clk); #1 rst = 1'b0;
    x = rnd_state();
    run_job("post_rst", perm(x, 6), 2'b00, 0, 0, res);
    chk_state("post_rst", res, x);

`ifdef ASCON_INV_ABORT_EN
    x = rnd_state();
    drive(perm(x, 12), 2'b10);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk_state("abort.out", outs(), '0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort.no_valid", 64'(seen), 64'd0);
    x = rnd_state();
    run_job("post_abort", perm(x, 8), 2'b01, 0, 0, res);
    chk_state("post_abort", res, x);
`else
    seen = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
